// File: rtl/mem_fill_pkg.sv
// rtl/mem_fill_pkg.sv - shared pattern-mode and FSM state encodings for the memory fill engine
package mem_fill_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'b00,
        MODE_INCR  = 2'b01,
        MODE_WALK  = 2'b10,
        MODE_ADDR  = 2'b11
    } fill_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fill_state_e;

endpackage

// File: rtl/fill_pattern_gen.sv
// rtl/fill_pattern_gen.sv - combinational data pattern P(i) for a given word index and address
module fill_pattern_gen
    import mem_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic [LEN_WIDTH-1:0]  index,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0]          shamt;
    logic [2*DATA_WIDTH-1:0] rot;

    // Select the pattern; walking-one rotates by shifting a doubled copy and keeping the upper half
    always_comb begin
        shamt = SHW'(32'(index) % DATA_WIDTH);
        rot   = {pattern, pattern} << shamt;
        case (mode)
            MODE_CONST: data = pattern;
            MODE_INCR:  data = pattern + DATA_WIDTH'(index);
            MODE_WALK:  data = rot[2*DATA_WIDTH-1:DATA_WIDTH];
            default:    data = DATA_WIDTH'(addr);
        endcase
    end

endmodule

// File: rtl/mem_fill_engine.sv
// rtl/mem_fill_engine.sv - memory fill engine with optional read-back check pass
module mem_fill_engine
    import mem_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  check_en,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  mismatch_count,
    output logic [ADDR_WIDTH-1:0] first_bad_addr
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [LEN_WIDTH-1:0]  ONE  = LEN_WIDTH'(1);

    fill_state_e state, state_nx;

    logic [1:0]            mode_q;
    logic                  chk_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] pat_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  cmp_valid;
    logic [LEN_WIDTH-1:0]  cmp_idx;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [LEN_WIDTH-1:0]  mism_q;
    logic [ADDR_WIDTH-1:0] first_bad_q;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  last_idx;
    logic                  accept;

    assign accept   = (state == ST_IDLE) && start;
    assign last_idx = (idx_q == len_q - ONE);

    // Write data follows the live index; check data follows the index of the read issued last cycle
    fill_pattern_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_gen_wr (
        .mode   (mode_q),
        .pattern(pat_q),
        .index  (idx_q),
        .addr   (addr_q),
        .data   (wr_data)
    );

    fill_pattern_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_gen_chk (
        .mode   (mode_q),
        .pattern(pat_q),
        .index  (cmp_idx),
        .addr   (cmp_addr),
        .data   (exp_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = (length == '0) ? ST_DONE : ST_FILL;
            ST_FILL:  if (last_idx) state_nx = chk_q ? ST_CHECK : ST_DONE;
            ST_CHECK: if (last_idx) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Outputs: memory bus is quiet (all zero) outside the access states
    always_comb begin
        busy      = (state == ST_FILL) || (state == ST_CHECK) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
        mem_we    = (state == ST_FILL);
        mem_re    = (state == ST_CHECK);
        mem_addr  = (mem_we || mem_re) ? addr_q : '0;
        mem_wdata = mem_we ? wr_data : '0;
    end

    // Operand latch, index/address walk, and read-back comparison one cycle behind each read
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q      <= '0;
            chk_q       <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            pat_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            cmp_valid   <= 1'b0;
            cmp_idx     <= '0;
            cmp_addr    <= '0;
            mism_q      <= '0;
            first_bad_q <= '0;
        end else begin
            cmp_valid <= 1'b0;
            if (accept) begin
                mode_q      <= mode;
                chk_q       <= check_en;
                base_q      <= base_addr;
                len_q       <= length;
                pat_q       <= pattern;
                idx_q       <= '0;
                addr_q      <= base_addr;
                mism_q      <= '0;
                first_bad_q <= '0;
            end else if (state == ST_FILL) begin
                if (last_idx) begin
                    idx_q  <= '0;
                    addr_q <= base_q;
                end else begin
                    idx_q  <= idx_q + ONE;
                    addr_q <= addr_q + STEP;
                end
            end else if (state == ST_CHECK) begin
                cmp_valid <= 1'b1;
                cmp_idx   <= idx_q;
                cmp_addr  <= addr_q;
                idx_q     <= idx_q + ONE;
                addr_q    <= addr_q + STEP;
            end
            if (cmp_valid && (mem_rdata != exp_data)) begin
                if (mism_q == '0) first_bad_q <= cmp_addr;
                if (mism_q != '1) mism_q <= mism_q + ONE;
            end
        end
    end

    assign mismatch_count = mism_q;
    assign first_bad_addr = first_bad_q;
    assign error          = (mism_q != '0);

endmodule
